// File: rtl/mdu_wb_arbiter.sv
// rtl/mdu_wb_arbiter.sv - imul/idiv writeback arbiter with per-source FIFOs and round-robin grant
package mdu_wb_pkg;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [5:0] rob_tag;
  } micro_op_t;
endpackage

module mdu_wb_arbiter
  import mdu_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imul_valid,
  input  micro_op_t   imul_uop,
  input  logic [31:0] imul_out,
  input  logic        idiv_valid,
  input  micro_op_t   idiv_uop,
  input  logic [31:0] idiv_out,
  input  logic        flush,
  output logic        wb_valid,
  output micro_op_t   wb_uop,
  output logic [31:0] wb_data,
  output logic        wb_src,
  input  logic        wb_ready,
  output logic        imul_full,
  output logic        idiv_full,
  output logic        overflow_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Index 0 is imul, index 1 is idiv, matching the wb_src encoding.
  logic        src_valid [2];
  micro_op_t   src_uop   [2];
  logic [31:0] src_data  [2];

  assign src_valid[0] = imul_valid;
  assign src_valid[1] = idiv_valid;
  assign src_uop[0]   = imul_uop;
  assign src_uop[1]   = idiv_uop;
  assign src_data[0]  = imul_out;
  assign src_data[1]  = idiv_out;

  logic [PW-1:0] wr_ptr   [2];
  logic [PW-1:0] rd_ptr   [2];
  logic [CW-1:0] cnt      [2];
  micro_op_t     mem_uop  [2][DEPTH];
  logic [31:0]   mem_data [2][DEPTH];

  logic nonempty [2];
  logic full     [2];
  logic push     [2];
  logic pop      [2];
  logic accept   [2];

  logic last_grant;
  logic lock;
  logic lock_src;
  logic grant;
  logic wb_fire;
  logic overflow_q;

  // Grant uses registered state only, so wb_* never depend on wb_ready or *_valid in the same cycle.
  always_comb begin
    grant = 1'b0;
    if (lock)
      grant = lock_src;
    else if (nonempty[0] && nonempty[1])
      grant = ~last_grant;
    else if (nonempty[1])
      grant = 1'b1;
  end

  // Per-source status and handshake decode; a push into a full FIFO is kept only if that FIFO pops too.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      nonempty[s] = (cnt[s] != '0);
      full[s]     = (cnt[s] == FULL_CNT);
      push[s]     = src_valid[s] && !flush;
      pop[s]      = wb_fire && (grant == 1'(s));
      accept[s]   = push[s] && (!full[s] || pop[s]);
    end
  end

  assign wb_valid     = nonempty[grant];
  assign wb_fire      = wb_valid && wb_ready;
  assign wb_src       = grant;
  assign wb_uop       = wb_valid ? mem_uop[grant][rd_ptr[grant]] : '0;
  assign wb_data      = wb_valid ? mem_data[grant][rd_ptr[grant]] : '0;
  assign imul_full    = full[0];
  assign idiv_full    = full[1];
  assign overflow_err = overflow_q;

  // Entry storage; contents need no reset because outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    for (int s = 0; s < 2; s++) begin
      if (accept[s]) begin
        mem_uop[s][wr_ptr[s]]  <= src_uop[s];
        mem_data[s][wr_ptr[s]] <= src_data[s];
      end
    end
  end

  // Pointers, counts, grant history, hold lock and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      last_grant <= 1'b1;
      lock       <= 1'b0;
      lock_src   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (flush) begin
          wr_ptr[s] <= '0;
          rd_ptr[s] <= '0;
          cnt[s]    <= '0;
        end else begin
          if (accept[s]) wr_ptr[s] <= wr_ptr[s] + 1'b1;
          if (pop[s])    rd_ptr[s] <= rd_ptr[s] + 1'b1;
          cnt[s] <= cnt[s] + CW'(accept[s]) - CW'(pop[s]);
        end
        if (push[s] && full[s] && !pop[s]) overflow_q <= 1'b1;
      end
      lock_src <= grant;
      if (flush) begin
        last_grant <= 1'b1;
        lock       <= 1'b0;
      end else begin
        if (wb_fire) last_grant <= grant;
        lock <= wb_valid && !wb_ready;
      end
    end
  end

endmodule

// File: tb/tb_mdu_wb_arbiter.sv
// tb/tb_mdu_wb_arbiter.sv - directed self-checking bench for mdu_wb_arbiter
module tb_mdu_wb_arbiter;
  import mdu_wb_pkg::*;

  logic        clock;
  logic        reset;
  logic        imul_valid;
  micro_op_t   imul_uop;
  logic [31:0] imul_out;
  logic        idiv_valid;
  micro_op_t   idiv_uop;
  logic [31:0] idiv_out;
  logic        flush;
  logic        wb_valid;
  micro_op_t   wb_uop;
  logic [31:0] wb_data;
  logic        wb_src;
  logic        wb_ready;
  logic        imul_full;
  logic        idiv_full;
  logic        overflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_wb_arbiter #(.DEPTH(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .imul_valid   (imul_valid),
    .imul_uop     (imul_uop),
    .imul_out     (imul_out),
    .idiv_valid   (idiv_valid),
    .idiv_uop     (idiv_uop),
    .idiv_out     (idiv_out),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_uop       (wb_uop),
    .wb_data      (wb_data),
    .wb_src       (wb_src),
    .wb_ready     (wb_ready),
    .imul_full    (imul_full),
    .idiv_full    (idiv_full),
    .overflow_err (overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic micro_op_t mk(input logic [4:0] rd, input logic [5:0] tag);
    micro_op_t u;
    u.valid   = 1'b1;
    u.rd      = rd;
    u.rob_tag = tag;
    return u;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    imul_valid = 1'b0;
    imul_uop   = '0;
    imul_out   = '0;
    idiv_valid = 1'b0;
    idiv_uop   = '0;
    idiv_out   = '0;
    flush      = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    wb_ready = 1'b0;
    reset    = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(wb_valid), 64'd0);
    check({tag, "_src"},   64'(wb_src), 64'd0);
    check({tag, "_data"},  64'(wb_data), 64'd0);
    check({tag, "_uop"},   64'(wb_uop), 64'd0);
    check({tag, "_imulf"}, 64'(imul_full), 64'd0);
    check({tag, "_idivf"}, 64'(idiv_full), 64'd0);
    check({tag, "_ovf"},   64'(overflow_err), 64'd0);
  endtask

  initial begin
    idle();
    wb_ready = 1'b0;
    reset    = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    check_all_zero("rst");

    // Single imul result, with no same-cycle bypass.
    wb_ready   = 1'b1;
    imul_valid = 1'b1;
    imul_out   = 32'h0000_0006;
    imul_uop   = mk(5'd3, 6'd7);
    #1;
    check("single_nobypass", 64'(wb_valid), 64'd0);
    cyc();
    idle();
    check("single_valid", 64'(wb_valid), 64'd1);
    check("single_data",  64'(wb_data), 64'h6);
    check("single_src",   64'(wb_src), 64'd0);
    check("single_uop",   64'(wb_uop), 64'(mk(5'd3, 6'd7)));
    cyc();
    check("single_empty", 64'(wb_valid), 64'd0);
    check("single_zdata", 64'(wb_data), 64'd0);
    check("single_zuop",  64'(wb_uop), 64'd0);

    // Simultaneous results from a fresh reset: imul first, then idiv.
    do_reset();
    wb_ready   = 1'b1;
    imul_valid = 1'b1; imul_out = 32'hA; imul_uop = mk(5'd1, 6'd1);
    idiv_valid = 1'b1; idiv_out = 32'hB; idiv_uop = mk(5'd2, 6'd2);
    cyc();
    idle();
    check("rr_a_data", 64'(wb_data), 64'hA);
    check("rr_a_src",  64'(wb_src), 64'd0);
    cyc();
    check("rr_b_data", 64'(wb_data), 64'hB);
    check("rr_b_src",  64'(wb_src), 64'd1);
    check("rr_b_uop",  64'(wb_uop), 64'(mk(5'd2, 6'd2)));
    cyc();
    check("rr_empty",  64'(wb_valid), 64'd0);

    // Stall and hold: idiv entry stays presented even when imul arrives and would win round-robin.
    do_reset();
    idiv_valid = 1'b1; idiv_out = 32'h11; idiv_uop = mk(5'd4, 6'd4);
    cyc();
    idle();
    check("hold1_data", 64'(wb_data), 64'h11);
    check("hold1_src",  64'(wb_src), 64'd1);
    cyc();
    imul_valid = 1'b1; imul_out = 32'h22; imul_uop = mk(5'd5, 6'd5);
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      check("hold_data", 64'(wb_data), 64'h11);
      check("hold_src",  64'(wb_src), 64'd1);
      cyc();
    end
    wb_ready = 1'b1;
    #1;
    check("hold_ready_data", 64'(wb_data), 64'h11);
    check("hold_ready_src",  64'(wb_src), 64'd1);
    cyc();
    check("hold_next_data", 64'(wb_data), 64'h22);
    check("hold_next_src",  64'(wb_src), 64'd0);
    cyc();
    check("hold_empty", 64'(wb_valid), 64'd0);

    // Full and overflow: third push into a stalled full FIFO is dropped.
    do_reset();
    imul_valid = 1'b1; imul_out = 32'd1;
    cyc();
    check("ovf_notfull", 64'(imul_full), 64'd0);
    imul_out = 32'd2;
    cyc();
    check("ovf_full",  64'(imul_full), 64'd1);
    check("ovf_clear", 64'(overflow_err), 64'd0);
    imul_out = 32'd3;
    cyc();
    idle();
    check("ovf_set",   64'(overflow_err), 64'd1);
    check("ovf_full2", 64'(imul_full), 64'd1);
    check("ovf_head1", 64'(wb_data), 64'd1);
    wb_ready = 1'b1;
    cyc();
    check("ovf_head2", 64'(wb_data), 64'd2);
    cyc();
    check("ovf_no3",    64'(wb_valid), 64'd0);
    check("ovf_sticky", 64'(overflow_err), 64'd1);

    // Push and pop on a full FIFO, then pointer wrap over 8 push/pop pairs.
    do_reset();
    imul_valid = 1'b1; imul_out = 32'd1;
    cyc();
    imul_out = 32'd2;
    cyc();
    check("pp_full", 64'(imul_full), 64'd1);
    wb_ready = 1'b1;
    imul_out = 32'd3;
    cyc();
    idle();
    check("pp_no_ovf", 64'(overflow_err), 64'd0);
    check("pp_head2",  64'(wb_data), 64'd2);
    check("pp_full2",  64'(imul_full), 64'd1);
    cyc();
    check("pp_head3",  64'(wb_data), 64'd3);
    for (int i = 0; i < 8; i++) begin
      imul_valid = 1'b1;
      imul_out   = 32'(16 + i);
      cyc();
      check("pp_wrap", 64'(wb_data), 64'(16 + i));
    end
    idle();
    cyc();
    check("pp_drain", 64'(wb_valid), 64'd0);
    check("pp_ovf",   64'(overflow_err), 64'd0);

    // Flush with both FIFOs full and an imul push in the flush cycle.
    do_reset();
    imul_valid = 1'b1; imul_out = 32'h31;
    idiv_valid = 1'b1; idiv_out = 32'h41;
    cyc();
    imul_out = 32'h32;
    idiv_out = 32'h42;
    cyc();
    check("fl_imulf", 64'(imul_full), 64'd1);
    check("fl_idivf", 64'(idiv_full), 64'd1);
    idle();
    flush      = 1'b1;
    imul_valid = 1'b1; imul_out = 32'h99;
    cyc();
    idle();
    check("fl_valid", 64'(wb_valid), 64'd0);
    check("fl_imulf0", 64'(imul_full), 64'd0);
    check("fl_idivf0", 64'(idiv_full), 64'd0);
    check("fl_ovf",    64'(overflow_err), 64'd0);
    wb_ready = 1'b1;
    cyc();
    check("fl_never", 64'(wb_valid), 64'd0);

    // Reset mid-operation with entries buffered and overflow set.
    wb_ready = 1'b0;
    imul_valid = 1'b1; imul_out = 32'h5;
    idiv_valid = 1'b1; idiv_out = 32'h6;
    cyc();
    cyc();
    cyc();
    idle();
    check("mid_valid", 64'(wb_valid), 64'd1);
    check("mid_ovf",   64'(overflow_err), 64'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_all_zero("mid_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_wb_arbiter.md
# mdu_wb_arbiter

Writeback arbiter for the multi-cycle integer units: buffers completed results from the `imul` and `idiv` function units and merges them onto one writeback port with a valid/ready handshake. Sits directly downstream of `imul` and `idiv`, and upstream of the common writeback/completion stage. Each source has its own small FIFO, which absorbs writeback-port stalls without losing results. Arbitration between the two sources is round-robin.

## Interface
- `DEPTH`, 2, entries per source FIFO; power of two, ≥ 2.
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `imul_valid`  in  1  imul result present this cycle.
- `imul_uop`  in  `micro_op_t`  uop of the completing multiply.
- `imul_out`  in  32  multiply result.
- `idiv_valid`  in  1  idiv result present this cycle; one-cycle pulse per division.
- `idiv_uop`  in  `micro_op_t`  uop of the completing divide.
- `idiv_out`  in  32  quotient.
- `flush`  in  1  pipeline flush; discards all buffered results.
- `wb_valid`  out  1  writeback entry presented.
- `wb_uop`  out  `micro_op_t`  uop of the presented entry.
- `wb_data`  out  32  result of the presented entry.
- `wb_src`  out  1  source of the presented entry: 0 = imul, 1 = idiv.
- `wb_ready`  in  1  consumer accepts the presented entry.
- `imul_full`  out  1  imul FIFO holds DEPTH entries.
- `idiv_full`  out  1  idiv FIFO holds DEPTH entries.
- `overflow_err`  out  1  sticky; set when a push hits a full FIFO that is not popped in the same cycle.

## Operation
- **FIFOs.** Two independent circular FIFOs (imul, idiv) of DEPTH entries each. Each entry holds {uop, data}.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
- **Push.** A FIFO is pushed when its `*_valid` is 1 and `flush` is 0.
- **Pop.** Pop occurs when `wb_valid & wb_ready`. Only the granted FIFO is popped.
- **Push and pop together, same FIFO:** both take effect and the count is unchanged. This holds when the FIFO is full: the push is accepted.
- **Push to a full FIFO without a pop that cycle:**
  - the entry is dropped;
  - FIFO contents and count are unchanged;
  - `overflow_err` is set to 1 and stays 1 until `reset`.
- **Arbitration.** `last_grant` is a 1-bit register, 0 = imul.
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the source ≠ `last_grant`.
  - `last_grant` updates to the granted source only on a pop.
- **Hold rule.** While `wb_valid=1` and `wb_ready=0`, `wb_uop`, `wb_data` and `wb_src` must not change. This holds even if the other FIFO becomes non-empty. Implement it with a registered lock bit.
- **Outputs.**
  - `wb_valid` = granted FIFO non-empty.
  - `wb_uop` and `wb_data` are the head entry of the granted FIFO.
  - When `wb_valid=0`, `wb_uop.valid` is forced to 0 and `wb_data` to 0.
- **Full flags.** `imul_full` and `idiv_full` are decoded from the registered counts. They do not depend combinationally on `wb_ready`.
- **Flush.** On `flush=1`, the following take effect next cycle:
  - both FIFOs empty, with pointers and counts reset to 0;
  - `last_grant` = 1;
  - lock cleared.

  Pushes in the flush cycle are discarded. A pop in the flush cycle is still a valid handshake and the consumer keeps that entry. `overflow_err` is not cleared by `flush`.
- **Reset.** Everything is cleared: FIFOs empty, `last_grant` = 1, lock = 0, `overflow_err` = 0.

## Timing
- **Latency.** An input pushed at cycle N is visible on `wb_*` at cycle N+1 at the earliest. There is no combinational bypass from `*_valid` to `wb_valid`.
- **Ready path.** `wb_ready` affects state only at the next posedge. It has no combinational effect on the `wb_*` outputs in the same cycle.
- **Throughput.** One pop per cycle. Back-to-back pops from the same FIFO are allowed when the other FIFO is empty.
- **Round-robin period.** With both FIFOs continuously non-empty and `wb_ready=1`, grants alternate every cycle.
- **Values after reset:**
  - `wb_valid`, `wb_src`, `wb_data`, `imul_full`, `idiv_full` and `overflow_err` are 0;
  - `wb_uop` is all-zero.
- **Reset mid-operation.** Buffered entries are lost. The first cycle after `reset` deasserts shows `wb_valid=0`.

## Test plan
- **Single imul result.** `imul_valid=1` with `imul_out=0x0000_0006` at cycle 5, `wb_ready=1` → at cycle 6: `wb_valid=1`, `wb_data=0x6`, `wb_src=0`. At cycle 7: `wb_valid=0`.
- **Simultaneous results, round-robin.** At cycle 3, imul pushes A and idiv pushes B (fresh after reset, `last_grant=1`), `wb_ready=1` → cycle 4 presents A (`wb_src=0`), cycle 5 presents B (`wb_src=1`), cycle 6 `wb_valid=0`.
- **Stall and hold.**
  - Stimulus: `wb_ready=0`; push idiv result 0x11; 2 cycles later push imul result 0x22; hold ready low for 5 cycles, then raise it.
  - Required: `wb_data` stays 0x11 with `wb_src=1` throughout the stall; the ready-high cycle pops 0x11; 0x22 appears in the following cycle.
- **Full and overflow, DEPTH=2.**
  - Stimulus: `wb_ready=0`; three consecutive imul pushes 1, 2, 3.
  - Required: `imul_full=1` after the 2nd push; the 3rd push is dropped and `overflow_err=1`. With `wb_ready=1` afterwards, the outputs are 1 then 2, with no 3.
- **Push/pop while full.** With the FIFO full at {1, 2} and `wb_ready=1`, push 3 in the same cycle → no `overflow_err`; outputs are 1, 2, 3 in order; pointers wrap correctly over 8 further push/pop pairs.
- **Flush and reset.**
  - Stimulus: fill both FIFOs, then assert `flush` together with an imul push.
  - Required: next cycle `wb_valid=0` and both full flags are 0; the pushed entry never appears.
  - Stimulus: assert `reset` with entries buffered.
  - Required: all outputs are 0 the following cycle.
